// File: rtl/pci_target_data_phase.sv
// PCI target data-phase controller.
// Sits behind the DEVSEL# stage. It captures the address and command of a memory
// read or write. It then runs single or burst data phases against a small internal
// word memory. It drives TRDY# and the AD output enable, and it honours IRDY# wait
// states.
//
// Handshake: a data word moves at a posedge where trdy==0 and irdy==0 (both active
// low). Either side holding its ready high inserts a wait state: no data moves and
// the address does not change. The target holds trdy and ad_out steady until the
// word is taken.
module pci_target_data_phase #(
  parameter int MEM_DEPTH = 8,
  parameter int ADDR_W    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame,
  input  logic        irdy,
  input  logic        devSelect,
  input  logic [31:0] ad_in,
  input  logic [3:0]  cbe,
  output logic [31:0] ad_out,
  output logic        ad_oe,
  output logic        trdy,
  output logic [2:0]  dbgState
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR_WAIT = 3'd1,
    TURN      = 3'd2,
    DATA      = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

  state_t              state, stateNext;
  logic                frameQ;
  logic [ADDR_W-1:0]   addr, addrNext, addrInc;
  logic [3:0]          cmd, cmdNext;
  logic                trdyNext, adOeNext;
  logic [31:0]         adOutNext;
  logic                memWe;
  logic                start;
  logic                isRead;
  logic [31:0]         mem [MEM_DEPTH];

  // A transaction starts on the first posedge where FRAME# is seen low after being high.
  assign start    = frameQ & ~frame;
  assign isRead   = (cmd == CMD_MEM_READ);
  assign addrInc  = addr + 1'b1;
  assign dbgState = state;

  // State, address, command and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      frameQ <= 1'b1;
      addr   <= '0;
      cmd    <= '0;
      trdy   <= 1'b1;
      ad_oe  <= 1'b0;
      ad_out <= '0;
    end else begin
      state  <= stateNext;
      frameQ <= frame;
      addr   <= addrNext;
      cmd    <= cmdNext;
      trdy   <= trdyNext;
      ad_oe  <= adOeNext;
      ad_out <= adOutNext;
    end
  end

  // Next-state and next-output logic for the data-phase sequencer.
  always_comb begin
    stateNext = state;
    addrNext  = addr;
    cmdNext   = cmd;
    trdyNext  = trdy;
    adOeNext  = ad_oe;
    adOutNext = ad_out;
    memWe     = 1'b0;

    case (state)
      IDLE: begin
        trdyNext = 1'b1;
        adOeNext = 1'b0;
        if (start) begin
          addrNext = ad_in[ADDR_W+1:2];
          cmdNext  = cbe;
          // Only memory read/write are claimed. Other commands leave the target idle.
          if (cbe == CMD_MEM_READ || cbe == CMD_MEM_WRITE) begin
            stateNext = ADDR_WAIT;
          end
        end
      end

      ADDR_WAIT: begin
        // DEVSEL# low means the target is claimed, so it takes priority over FRAME#
        // sampled high on the same edge.
        if (!devSelect) begin
          if (isRead) begin
            stateNext = TURN;
            adOeNext  = 1'b1;
            adOutNext = mem[addr];
            trdyNext  = 1'b1;
          end else begin
            stateNext = DATA;
            trdyNext  = 1'b0;
          end
        end else if (frame) begin
          // Master abort: FRAME# went away before the target was selected.
          stateNext = IDLE;
        end
      end

      TURN: begin
        // One turnaround cycle on AD, then the first read word is offered.
        stateNext = DATA;
        trdyNext  = 1'b0;
      end

      DATA: begin
        if (!trdy && !irdy) begin
          addrNext = addrInc;
          if (isRead) begin
            adOutNext = mem[addrInc];
          end else begin
            memWe = 1'b1;
          end
          if (frame) begin
            stateNext = DONE;
            trdyNext  = 1'b1;
            adOeNext  = 1'b0;
          end
        end
      end

      DONE: begin
        stateNext = IDLE;
        trdyNext  = 1'b1;
        adOeNext  = 1'b0;
      end

      default: begin
        stateNext = IDLE;
        trdyNext  = 1'b1;
        adOeNext  = 1'b0;
      end
    endcase
  end

  // Target memory. Reset clears it. Writes merge only the bytes whose active-low enable is 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (memWe) begin
      for (int b = 0; b < 4; b++) begin
        if (!cbe[b]) begin
          mem[addr][8*b +: 8] <= ad_in[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_pci_target_data_phase.sv
// Directed bench for pci_target_data_phase.
// A reference word array tracks what the target memory should hold. Read bursts
// queue the words they expect, then compare each one against ad_out before the edge
// that transfers it.
module tb_pci_target_data_phase;

  logic        clk;
  logic        rst;
  logic        frame;
  logic        irdy;
  logic        devSelect;
  logic [31:0] ad_in;
  logic [3:0]  cbe;
  logic [31:0] ad_out;
  logic        ad_oe;
  logic        trdy;
  logic [2:0]  dbgState;

  int checks;
  int failures;

  logic [31:0] model [0:7];
  logic [31:0] wd    [0:7];
  logic [3:0]  wbe   [0:7];
  logic [31:0] exp_q [$];

  pci_target_data_phase #(.MEM_DEPTH(8), .ADDR_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .frame     (frame),
    .irdy      (irdy),
    .devSelect (devSelect),
    .ad_in     (ad_in),
    .cbe       (cbe),
    .ad_out    (ad_out),
    .ad_oe     (ad_oe),
    .trdy      (trdy),
    .dbgState  (dbgState)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write burst of n phases from wd/wbe. IRDY# is ready on every phase, and FRAME#
  // rises with the last word.
  task automatic write_burst(input logic [31:0] byteAddr, input int n);
    frame = 1'b0; ad_in = byteAddr; cbe = 4'b0111; irdy = 1'b1; devSelect = 1'b1;
    step();
    check("wr_addr_wait_state", dbgState, 3'd1);
    check("wr_addr_wait_trdy", trdy, 1'b1);
    devSelect = 1'b0;
    step();
    check("wr_latency_trdy", trdy, 1'b0);
    check("wr_data_state", dbgState, 3'd3);
    check("wr_ad_oe_off", ad_oe, 1'b0);
    for (int i = 0; i < n; i++) begin
      ad_in = wd[i]; cbe = wbe[i]; irdy = 1'b0; frame = (i == n - 1);
      step();
      if (i < n - 1) check("wr_burst_trdy", trdy, 1'b0);
    end
    check("wr_done_state", dbgState, 3'd4);
    check("wr_done_trdy", trdy, 1'b1);
    frame = 1'b1; irdy = 1'b1; devSelect = 1'b1; cbe = 4'b0000;
    step();
    check("wr_back_idle", dbgState, 3'd0);
  endtask

  // Read burst of n phases. IRDY# is held high for waitLen cycles before phase waitAt.
  task automatic read_burst(input logic [31:0] byteAddr, input int n, input int waitAt,
                            input int waitLen);
    logic [2:0]  wa;
    logic [2:0]  idx;
    logic [31:0] exp;
    wa = byteAddr[4:2];
    for (int i = 0; i < n; i++) begin
      idx = wa + 3'(i);
      exp_q.push_back(model[idx]);
    end
    frame = 1'b0; ad_in = byteAddr; cbe = 4'b0110; irdy = 1'b1; devSelect = 1'b1;
    step();
    check("rd_addr_wait_state", dbgState, 3'd1);
    devSelect = 1'b0;
    step();
    check("rd_turn_state", dbgState, 3'd2);
    check("rd_turn_trdy", trdy, 1'b1);
    check("rd_turn_ad_oe", ad_oe, 1'b1);
    step();
    check("rd_latency_trdy", trdy, 1'b0);
    for (int i = 0; i < n; i++) begin
      exp = exp_q.pop_front();
      if (i == waitAt) begin
        for (int w = 0; w < waitLen; w++) begin
          irdy = 1'b1; frame = 1'b0;
          step();
          check("rd_wait_ad_out", ad_out, exp);
          check("rd_wait_trdy", trdy, 1'b0);
        end
      end
      check("rd_data", ad_out, exp);
      check("rd_data_ad_oe", ad_oe, 1'b1);
      irdy = 1'b0; frame = (i == n - 1);
      step();
    end
    check("rd_done_state", dbgState, 3'd4);
    check("rd_done_trdy", trdy, 1'b1);
    check("rd_done_ad_oe", ad_oe, 1'b0);
    frame = 1'b1; irdy = 1'b1; devSelect = 1'b1; cbe = 4'b0000;
    step();
    check("rd_back_idle", dbgState, 3'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    rst = 1'b1; frame = 1'b1; irdy = 1'b1; devSelect = 1'b1; ad_in = 32'h0; cbe = 4'h0;
    step();
    step();
    rst = 1'b0;
    check("reset_trdy", trdy, 1'b1);
    check("reset_ad_oe", ad_oe, 1'b0);
    check("reset_ad_out", ad_out, 32'h0);
    check("reset_state", dbgState, 3'd0);

    // Single full-word write to word 2.
    wd[0] = 32'hDEADBEEF; wbe[0] = 4'b0000;
    write_burst(32'h08, 1);
    model[2] = 32'hDEADBEEF;

    // Byte-enable write: only bytes 0 and 2 are enabled.
    wd[0] = 32'h11223344; wbe[0] = 4'b1010;
    write_burst(32'h08, 1);
    model[2] = 32'hDE22BE44;
    read_burst(32'h08, 1, -1, 0);

    // Write burst that wraps from word 7 to word 0.
    wd[0] = 32'hA0A0A0A0; wd[1] = 32'hA1A1A1A1; wd[2] = 32'hA2A2A2A2; wd[3] = 32'hA3A3A3A3;
    for (int i = 0; i < 4; i++) wbe[i] = 4'b0000;
    write_burst(32'h18, 4);
    model[6] = 32'hA0A0A0A0; model[7] = 32'hA1A1A1A1;
    model[0] = 32'hA2A2A2A2; model[1] = 32'hA3A3A3A3;

    // Read burst that wraps: words 6, 7, 0, 1.
    read_burst(32'h18, 4, -1, 0);

    // Read burst with a 3-cycle IRDY# wait before the third phase.
    read_burst(32'h00, 4, 2, 3);

    // Master abort: FRAME# returns high before DEVSEL# is ever low.
    frame = 1'b0; ad_in = 32'h08; cbe = 4'b0111; irdy = 1'b1; devSelect = 1'b1;
    step();
    check("abort_addr_wait", dbgState, 3'd1);
    frame = 1'b1; ad_in = 32'hFFFFFFFF; cbe = 4'b0000; irdy = 1'b0;
    step();
    check("abort_idle", dbgState, 3'd0);
    check("abort_trdy", trdy, 1'b1);
    step();
    check("abort_trdy_later", trdy, 1'b1);
    irdy = 1'b1;

    // A non-memory command is not claimed.
    frame = 1'b0; ad_in = 32'h08; cbe = 4'b0010;
    step();
    check("nonmem_idle", dbgState, 3'd0);
    check("nonmem_trdy", trdy, 1'b1);
    frame = 1'b1;
    step();
    read_burst(32'h08, 1, -1, 0);

    // Reset during the second phase of a write burst.
    frame = 1'b0; ad_in = 32'h00; cbe = 4'b0111; irdy = 1'b1; devSelect = 1'b1;
    step();
    devSelect = 1'b0;
    step();
    ad_in = 32'hCAFEF00D; cbe = 4'b0000; irdy = 1'b0; frame = 1'b0;
    step();
    check("rstmid_phase2_trdy", trdy, 1'b0);
    ad_in = 32'h12345678; rst = 1'b1; frame = 1'b1;
    step();
    check("rstmid_trdy", trdy, 1'b1);
    check("rstmid_ad_oe", ad_oe, 1'b0);
    check("rstmid_state", dbgState, 3'd0);
    check("rstmid_ad_out", ad_out, 32'h0);
    rst = 1'b0; irdy = 1'b1; devSelect = 1'b1;
    step();
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    read_burst(32'h00, 8, -1, 0);

    // A new transfer works after the reset.
    wd[0] = 32'h5A5AA5A5; wbe[0] = 4'b0000;
    write_burst(32'h0C, 1);
    model[3] = 32'h5A5AA5A5;
    read_burst(32'h08, 2, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
